// File: rtl/wb_port_arbiter_if.sv
// Bus bundle for the register-file write-port arbiter: pipe and aux write
// requests, the register-file write port, and the RAW hazard lookup.
interface wb_port_arbiter_if #(
  parameter int XLEN      = 32,
  parameter int REG_AW    = 5,
  parameter int AUX_DEPTH = 2
);
  logic                           pipe_valid;
  logic                           pipe_ready;
  logic [REG_AW-1:0]              pipe_rd_addr;
  logic [XLEN-1:0]                pipe_rd_data;
  logic                           aux_valid;
  logic                           aux_ready;
  logic [REG_AW-1:0]              aux_rd_addr;
  logic [XLEN-1:0]                aux_rd_data;
  logic                           rf_write;
  logic [REG_AW-1:0]              rf_addr;
  logic [XLEN-1:0]                rf_wdata;
  logic [REG_AW-1:0]              chk_addr;
  logic                           chk_pending;
  logic [$clog2(AUX_DEPTH):0]     aux_count;

  modport slave (
    input  pipe_valid, pipe_rd_addr, pipe_rd_data,
    input  aux_valid, aux_rd_addr, aux_rd_data, chk_addr,
    output pipe_ready, aux_ready, rf_write, rf_addr, rf_wdata,
    output chk_pending, aux_count
  );

  modport master (
    output pipe_valid, pipe_rd_addr, pipe_rd_data,
    output aux_valid, aux_rd_addr, aux_rd_data, chk_addr,
    input  pipe_ready, aux_ready, rf_write, rf_addr, rf_wdata,
    input  chk_pending, aux_count
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipe writeback has priority, aux results
// wait in an in-order FIFO, and a starvation counter forces an aux slot.
module wb_port_arbiter #(
  parameter int XLEN         = 32,
  parameter int REG_AW       = 5,
  parameter int AUX_DEPTH    = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst_b,
  wb_port_arbiter_if.slave bus
);
  localparam int PW = $clog2(AUX_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(AUX_DEPTH);
  localparam logic [3:0]    LIMIT_C = 4'(STARVE_LIMIT);

  logic [REG_AW-1:0] addr_mem_r [AUX_DEPTH];
  logic [XLEN-1:0]   data_mem_r [AUX_DEPTH];
  logic [PW-1:0]     rd_ptr_r;
  logic [PW-1:0]     wr_ptr_r;
  logic [CW-1:0]     count_r;
  logic [3:0]        starve_r;

  logic              nonempty_s;
  logic              force_s;
  logic              push_s;
  logic              grant_pipe_s;
  logic              grant_aux_s;
  logic [REG_AW-1:0] sel_addr_s;
  logic [XLEN-1:0]   sel_data_s;
  logic              chk_hit_s;

  assign nonempty_s = (count_r != {CW{1'b0}});
  assign force_s    = (starve_r == LIMIT_C);
  // A same-cycle pop does not make room for a same-cycle push.
  assign push_s     = bus.aux_valid & (count_r != DEPTH_C);

  // Grant selection and write-port mux
  always_comb begin
    grant_pipe_s = 1'b0;
    grant_aux_s  = 1'b0;
    sel_addr_s   = {REG_AW{1'b0}};
    sel_data_s   = {XLEN{1'b0}};
    if (force_s && nonempty_s) begin
      grant_aux_s = 1'b1;
    end else if (bus.pipe_valid) begin
      grant_pipe_s = 1'b1;
    end else if (nonempty_s) begin
      grant_aux_s = 1'b1;
    end else begin
      grant_aux_s = 1'b0;
    end
    if (grant_pipe_s) begin
      sel_addr_s = bus.pipe_rd_addr;
      sel_data_s = bus.pipe_rd_data;
    end else if (grant_aux_s) begin
      sel_addr_s = addr_mem_r[rd_ptr_r];
      sel_data_s = data_mem_r[rd_ptr_r];
    end else begin
      sel_addr_s = {REG_AW{1'b0}};
      sel_data_s = {XLEN{1'b0}};
    end
  end

  // Hazard lookup over occupied slots, including the head being popped
  always_comb begin
    logic [PW-1:0] off_s;
    chk_hit_s = 1'b0;
    off_s     = {PW{1'b0}};
    for (int i = 0; i < AUX_DEPTH; i++) begin
      off_s     = PW'(i) - rd_ptr_r;
      chk_hit_s = chk_hit_s |
                  (({1'b0, off_s} < count_r) && (addr_mem_r[i] == bus.chk_addr));
    end
  end

  assign bus.pipe_ready  = ~(force_s & nonempty_s);
  assign bus.aux_ready   = (count_r != DEPTH_C);
  assign bus.rf_write    = (grant_pipe_s | grant_aux_s) & (sel_addr_s != {REG_AW{1'b0}});
  assign bus.rf_addr     = sel_addr_s;
  assign bus.rf_wdata    = sel_data_s;
  assign bus.chk_pending = chk_hit_s & (bus.chk_addr != {REG_AW{1'b0}});
  assign bus.aux_count   = count_r;

  // FIFO storage; contents are qualified by count, so no reset is needed
  always_ff @(posedge clk) begin
    if (push_s) begin
      addr_mem_r[wr_ptr_r] <= bus.aux_rd_addr;
      data_mem_r[wr_ptr_r] <= bus.aux_rd_data;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst_b) begin
      rd_ptr_r <= {PW{1'b0}};
      wr_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (grant_aux_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({push_s, grant_aux_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Starvation counter: counts pipe wins over a waiting aux entry
  always_ff @(posedge clk) begin
    if (rst_b) begin
      starve_r <= 4'd0;
    end else if (grant_aux_s) begin
      starve_r <= 4'd0;
    end else if (grant_pipe_s && nonempty_s && (starve_r != LIMIT_C)) begin
      starve_r <= starve_r + 4'd1;
    end else begin
      starve_r <= starve_r;
    end
  end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Randomized and directed bench for wb_port_arbiter against a queue-based
// reference model of the arbitration rules.
module tb_wb_port_arbiter;
  localparam int XLEN  = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  typedef struct packed {
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
  } ent_t;

  logic clk;
  logic rst_b;
  int   total;
  int   bad;

  ent_t q[$];
  int   starve_m;
  int   exp_grant;
  logic exp_push;
  logic exp_aux_ready;
  logic s_pv;
  logic s_av;
  logic s_rst;
  logic [AW-1:0]   s_pa, s_aa;
  logic [XLEN-1:0] s_pd, s_ad;

  wb_port_arbiter_if #(.XLEN(XLEN), .REG_AW(AW), .AUX_DEPTH(DEPTH)) bus ();

  wb_port_arbiter #(.XLEN(XLEN), .REG_AW(AW), .AUX_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Apply one cycle of inputs at the falling edge and check outputs against the model.
  task automatic drive(input logic pv, input logic [AW-1:0] pa, input logic [XLEN-1:0] pd,
                       input logic av, input logic [AW-1:0] aa, input logic [XLEN-1:0] ad,
                       input logic [AW-1:0] ca, input logic rs);
    logic ne, frc, pend, ew;
    logic [AW-1:0] ea;
    logic [XLEN-1:0] ed;
    @(negedge clk);
    bus.pipe_valid = pv; bus.pipe_rd_addr = pa; bus.pipe_rd_data = pd;
    bus.aux_valid = av;  bus.aux_rd_addr = aa;  bus.aux_rd_data = ad;
    bus.chk_addr = ca;   rst_b = rs;
    s_pv = pv; s_pa = pa; s_pd = pd; s_av = av; s_aa = aa; s_ad = ad; s_rst = rs;
    #1;
    ne  = (q.size() > 0);
    frc = (starve_m == LIMIT);
    if (frc && ne) exp_grant = 2;
    else if (pv) exp_grant = 1;
    else if (ne) exp_grant = 2;
    else exp_grant = 0;
    ea = '0; ed = '0;
    if (exp_grant == 1) begin ea = pa; ed = pd; end
    if (exp_grant == 2) begin ea = q[0].addr; ed = q[0].data; end
    ew = (exp_grant != 0) && (ea != '0);
    pend = 1'b0;
    foreach (q[i]) if (ca != '0 && q[i].addr == ca) pend = 1'b1;
    exp_aux_ready = (q.size() != DEPTH);
    exp_push = av && exp_aux_ready;
    check_value("rf_write",    64'(bus.rf_write),    64'(ew));
    check_value("rf_addr",     64'(bus.rf_addr),     64'(ea));
    check_value("rf_wdata",    64'(bus.rf_wdata),    64'(ed));
    check_value("pipe_ready",  64'(bus.pipe_ready),  64'(!(frc && ne)));
    check_value("aux_ready",   64'(bus.aux_ready),   64'(exp_aux_ready));
    check_value("chk_pending", 64'(bus.chk_pending), 64'(pend));
    check_value("aux_count",   64'(bus.aux_count),   64'(q.size()));
  endtask

  // Advance one clock and update the model with the cycle's decisions.
  task automatic step();
    logic was_ne;
    @(posedge clk);
    if (s_rst) begin
      q.delete();
      starve_m = 0;
    end else begin
      was_ne = (q.size() > 0);
      if (exp_grant == 2) begin
        void'(q.pop_front());
        starve_m = 0;
      end else if (exp_grant == 1 && was_ne && starve_m < LIMIT) begin
        starve_m++;
      end
      if (exp_push) q.push_back({s_aa, s_ad});
    end
  endtask

  initial begin
    logic hold;
    ent_t held;
    logic [AW-1:0] items [3];
    int idx;
    total = 0; bad = 0; starve_m = 0; exp_grant = 0; exp_push = 1'b0;
    bus.pipe_valid = 1'b0; bus.pipe_rd_addr = '0; bus.pipe_rd_data = '0;
    bus.aux_valid = 1'b0;  bus.aux_rd_addr = '0;  bus.aux_rd_data = '0;
    bus.chk_addr = '0;     rst_b = 1'b1;
    repeat (2) @(posedge clk);

    // Reset state
    drive(1'b0, '0, '0, 1'b0, '0, '0, 5'd0, 1'b0);
    check_value("rst_rf_write", 64'(bus.rf_write), 64'd0);
    check_value("rst_aux_ready", 64'(bus.aux_ready), 64'd1);
    check_value("rst_pipe_ready", 64'(bus.pipe_ready), 64'd1);
    check_value("rst_count", 64'(bus.aux_count), 64'd0);
    step();

    // Zero-latency pipe write
    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0, 5'd0, 1'b0);
    check_value("pipe_wr", 64'(bus.rf_write), 64'd1);
    check_value("pipe_addr", 64'(bus.rf_addr), 64'd5);
    check_value("pipe_data", 64'(bus.rf_wdata), 64'hDEADBEEF);
    step();

    // Aux push then pop next cycle
    drive(1'b0, '0, '0, 1'b1, 5'd7, 32'h1234, 5'd7, 1'b0);
    check_value("aux_nobypass", 64'(bus.rf_write), 64'd0);
    step();
    drive(1'b0, '0, '0, 1'b0, '0, '0, 5'd7, 1'b0);
    check_value("aux_wr_addr", 64'(bus.rf_addr), 64'd7);
    check_value("aux_pend", 64'(bus.chk_pending), 64'd1);
    check_value("aux_cnt1", 64'(bus.aux_count), 64'd1);
    step();
    drive(1'b0, '0, '0, 1'b0, '0, '0, 5'd7, 1'b0);
    check_value("aux_pend_gone", 64'(bus.chk_pending), 64'd0);
    step();

    // Starvation: four pipe wins, one forced aux slot, pipe resumes
    drive(1'b1, 5'd3, 32'h3, 1'b1, 5'd9, 32'h99, 5'd0, 1'b0);
    step();
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 5'(k + 10), 32'(k), 1'b0, '0, '0, 5'd9, 1'b0);
      check_value("starve_pready", 64'(bus.pipe_ready), 64'(k != 4));
      check_value("starve_addr", 64'(bus.rf_addr), (k == 4) ? 64'd9 : 64'(k + 10));
      step();
    end

    // Fill the FIFO with pipe busy; third entry is held by the producer
    items[0] = 5'd21; items[1] = 5'd22; items[2] = 5'd23;
    idx = 0;
    for (int c = 0; c < 8; c++) begin
      drive(1'b1, 5'd20, 32'(c), idx < 3, (idx < 3) ? items[idx] : 5'd0, 32'(100 + idx), 5'd22, 1'b0);
      if (c == 2) check_value("full_aux_ready", 64'(bus.aux_ready), 64'd0);
      if (exp_push) idx++;
      step();
    end
    for (int c = 0; c < 4; c++) begin
      drive(1'b0, '0, '0, 1'b0, '0, '0, 5'd23, 1'b0);
      step();
    end

    // x0 writes are consumed but never reach the register file
    drive(1'b1, 5'd0, 32'hFFFF, 1'b1, 5'd0, 32'hAAAA, 5'd0, 1'b0);
    check_value("x0_pipe", 64'(bus.rf_write), 64'd0);
    step();
    drive(1'b0, '0, '0, 1'b0, '0, '0, 5'd0, 1'b0);
    check_value("x0_aux", 64'(bus.rf_write), 64'd0);
    check_value("x0_cnt", 64'(bus.aux_count), 64'd1);
    step();
    drive(1'b0, '0, '0, 1'b0, '0, '0, 5'd0, 1'b0);
    check_value("x0_popped", 64'(bus.aux_count), 64'd0);
    step();

    // Reset discards buffered entries
    drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd11, 32'hB1, 5'd0, 1'b0); step();
    drive(1'b1, 5'd2, 32'h2, 1'b1, 5'd12, 32'hB2, 5'd0, 1'b0); step();
    drive(1'b1, 5'd3, 32'h3, 1'b0, '0, '0, 5'd0, 1'b1);         step();
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, '0, '0, 1'b0, '0, '0, 5'd11, 1'b0);
      check_value("post_rst_wr", 64'(bus.rf_write), 64'd0);
      check_value("post_rst_cnt", 64'(bus.aux_count), 64'd0);
      step();
    end

    // Randomized traffic; the aux producer holds data while not accepted
    hold = 1'b0; held = '0;
    for (int n = 0; n < 3000; n++) begin
      logic av, rs;
      if (!hold) begin
        av = ($urandom_range(0, 2) != 0);
        held = {5'($urandom_range(0, 7)), 32'($urandom)};
      end else begin
        av = 1'b1;
      end
      rs = ($urandom_range(0, 99) == 0);
      drive($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), 32'($urandom),
            av, held.addr, held.data, 5'($urandom_range(0, 7)), rs);
      hold = av && !exp_push && !rs;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between two writers:
  - the in-order pipeline writeback (pipe);
  - a long-latency unit (aux), for example a divider or uncached load return.
- Aux results are buffered in a small FIFO.
- The pipe has priority, bounded by a starvation limit.
- A lookup port reports pending aux writes so decode can stall on RAW hazards.
- Sits between the writeback stage and the register file.

Parameters:
- XLEN, 32, data width.
- REG_AW, 5, register address width.
- AUX_DEPTH, 2, aux FIFO entries; power of 2, at least 2.
- STARVE_LIMIT, 4, consecutive pipe grants with aux waiting before one aux slot is forced; range 1..15.

Ports:
- clk  in  1  clock.
- rst_b  in  1  reset, synchronous, active-high.
- pipe_valid  in  1  pipe write request; already qualified by rd_write and the instruction's valid.
- pipe_ready  out  1  pipe write accepted this cycle.
- pipe_rd_addr  in  REG_AW  pipe destination.
- pipe_rd_data  in  XLEN  pipe write data.
- aux_valid  in  1  aux result valid.
- aux_ready  out  1  aux FIFO can accept.
- aux_rd_addr  in  REG_AW  aux destination.
- aux_rd_data  in  XLEN  aux write data.
- rf_write  out  1  register-file write enable.
- rf_addr  out  REG_AW  register-file write address.
- rf_wdata  out  XLEN  register-file write data.
- chk_addr  in  REG_AW  hazard lookup address.
- chk_pending  out  1  a FIFO entry targets chk_addr, with chk_addr != 0.
- aux_count  out  $clog2(AUX_DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (rst_b=1 at a clk edge):
  - FIFO emptied: rd_ptr=wr_ptr=0, aux_count=0.
  - Starvation counter = 0, force flag = 0.
  - Outputs after reset: rf_write=0, aux_ready=1, pipe_ready=1, chk_pending=0.
  - Reset mid-operation discards buffered aux results without writing them.
- aux_ready is driven only by occupancy: aux_ready = (aux_count != AUX_DEPTH). A same-cycle pop does not free a slot for a same-cycle push.
- Push: aux_valid & aux_ready at the clock edge writes {addr, data} at wr_ptr; the pointer wraps modulo AUX_DEPTH.
- Arbitration (combinational, same cycle):
  - force=1 and FIFO non-empty: grant aux (pop head); pipe_ready=0.
  - Otherwise, pipe_valid=1: grant pipe; pipe_ready=1.
  - Otherwise, FIFO non-empty: grant aux.
  - Otherwise: no write.
  - pipe_ready = ~(force & non-empty), independent of pipe_valid.
- Latency:
  - Pipe write appears on rf_* in the same cycle: 0 latency.
  - An aux entry is written no earlier than the cycle after its push; there is no FIFO bypass.
- rf_write = granted & (granted addr != 0). An x0 write is consumed and popped but rf_write stays 0.
- rf_addr/rf_wdata follow the granted source. They are 0 when nothing is granted.
- Starvation counter:
  - Increments, saturating at STARVE_LIMIT, when the pipe is granted while the FIFO is non-empty.
  - Clears on any aux pop.
  - force = (counter == STARVE_LIMIT).
  - After a forced aux grant the counter is 0; force drops next cycle.
- Ordering:
  - The FIFO is strictly in order.
  - The arbiter never reorders a pipe write against an aux write to the same rd. Decode stalls on chk_pending to prevent that WAW/RAW case.
- chk_pending:
  - Combinational OR over valid entries of (entry.addr == chk_addr).
  - Excludes chk_addr == 0.
  - Includes an entry being popped this cycle, so it is conservative.
- Simultaneous push and pop when not full: occupancy is unchanged and both pointers advance.
- Full FIFO with aux_valid high: aux_ready=0 and the aux producer holds its data.
- Empty FIFO: force has no effect and pipe_ready=1.

Test Plan:
- Reset, then pipe_valid=1, addr 5, data 0xDEADBEEF -> same cycle rf_write=1, rf_addr=5, rf_wdata=0xDEADBEEF, pipe_ready=1.
- Aux push of addr 7, data 0x1234 with pipe idle -> next cycle rf_write=1, rf_addr=7; aux_count 1->0; chk_pending(7)=1 only in the cycle before the pop edge.
- Pipe_valid held high, one aux entry pushed, STARVE_LIMIT=4:
  - 4 pipe writes.
  - 5th cycle: pipe_ready=0, aux written.
  - 6th cycle: pipe resumes.
- Push 3 aux entries back-to-back with pipe busy and AUX_DEPTH=2 -> aux_ready=0 after 2 pushes; the third is held. Entries drain in push order.
- Pipe writes addr 0 and an aux entry with addr 0 -> rf_write=0 for both; the aux entry is popped (aux_count decrements).
- Two entries buffered, then rst_b=1 for one cycle -> aux_count=0, rf_write=0, and no buffered write ever appears.
